note_sequencer: RTL and testbench
=================================

NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 The block SHALL have parameter SONG0_BASE, default 8'd0, meaning the first ROM address of song 0.
REQ-002 The block SHALL have parameter SONG1_BASE, default 8'd139, meaning the first ROM address of song 1.
REQ-003 The block SHALL have port CLK  input  1  system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port RST_N  input  1  asynchronous reset, active-low.
REQ-005 The block SHALL have port BEAT_EN  input  1  one-CLK-cycle pulse per 0.25 s beat, synchronous to CLK.
REQ-006 The block SHALL have port SONG_SEL  input  1  raw switch input that selects song 0 or song 1.
REQ-007 The block SHALL have port PAUSE  input  1  level input that freezes playback while high.
REQ-008 The block SHALL have port ROM_ADDR  output  8  music ROM read address.
REQ-009 The block SHALL have port ROM_Q  input  8  ROM word, where [3:0] is the note code and [7:4] is the duration in beats minus one, valid one CLK after ROM_ADDR.
REQ-010 The block SHALL have port INX  output  4  current note code to the frequency-code lookup, where 4'h0 means rest.
REQ-011 The block SHALL have port NOTE_VALID  output  1  high while a note from ROM is sounding.
REQ-012 The block SHALL have port SONG_ID  output  1  synchronized song currently selected.

Function
REQ-013 SONG_SEL SHALL pass through a 2-flop synchronizer, and SONG_ID SHALL equal the synchronized value.
REQ-014 The FSM SHALL have states IDLE, FETCH, LOAD, PLAY and DONE.
REQ-015 IDLE SHALL go to FETCH unconditionally on the next cycle.
REQ-016 FETCH SHALL hold ROM_ADDR for one cycle and then go to LOAD.
REQ-017 In LOAD, if ROM_Q[3:0] != 4'hF, the block SHALL set INX = ROM_Q[3:0], set remaining = ROM_Q[7:4]+1 (5-bit, range 1..16), set NOTE_VALID = 1, set ROM_ADDR = ROM_ADDR+1 (8-bit wrap 255 -> 0), and go to PLAY.
REQ-018 In LOAD, if ROM_Q[3:0] == 4'hF (end marker), the block SHALL apply end-of-song handling per REQ-027.
REQ-019 In PLAY, each BEAT_EN with PAUSE low SHALL decrement remaining; when remaining == 1 the block SHALL go to FETCH instead of decrementing.
REQ-020 A note SHALL therefore sound for exactly ROM_Q[7:4]+1 beats, and the next INX SHALL appear 2 CLK cycles after the final BEAT_EN.
REQ-021 INX and NOTE_VALID SHALL hold their values through FETCH and LOAD between notes, with no glitch to rest.
REQ-022 While PAUSE is high, INX SHALL read 4'h0, NOTE_VALID SHALL read 0, and remaining and the state SHALL be frozen; after PAUSE falls, the held note SHALL resume.
REQ-023 A change of the synchronized SONG_SEL SHALL, on the next cycle and from any state, set INX = 0, set NOTE_VALID = 0, load ROM_ADDR with the new base, and go to FETCH.
REQ-024 A song change SHALL take priority over BEAT_EN and PAUSE in the same cycle.
REQ-025 An end marker at the song base address (empty song) SHALL send the block to DONE regardless of configuration, to avoid an infinite refetch loop.

Reset
REQ-026 While RST_N is low, the block SHALL force state = IDLE, ROM_ADDR = SONG0_BASE or SONG1_BASE per the synchronizer output, INX = 0, NOTE_VALID = 0 and remaining = 0, with synchronizer flops cleared to 0; a reset mid-note SHALL abandon the note immediately.

Configuration
REQ-027 With macro NOTE_SEQ_LOOP_EN defined, an end marker SHALL set ROM_ADDR = current song base and go to FETCH, looping the song; without it, an end marker SHALL go to DONE with INX = 0 and NOTE_VALID = 0, and the block SHALL stay in DONE until a song change or reset.

Structure
REQ-028 Package note_seq_pkg SHALL hold the FSM state enum, END_CODE = 4'hF, REST_CODE = 4'h0, and the field widths NOTE_W = 4 and DUR_W = 4.
REQ-029 The synchronizer SHALL be sub-module sync_2ff (1-bit, async active-low clear); all other logic SHALL be in note_sequencer.

Verification
REQ-030 The bench SHALL apply ROM[0] = 8'h25 and ROM[1] = 8'h06, then pulse BEAT_EN, and SHALL check that INX = 5 for exactly 3 beats and then INX = 6 two cycles after the 3rd pulse.
REQ-031 The bench SHALL toggle PAUSE high for 10 beats during a 2-beat note, and SHALL check that INX = 0 while paused and that the note resumes with 2 beats remaining.
REQ-032 The bench SHALL place an end marker at address 3 with NOTE_SEQ_LOOP_EN defined, and SHALL check that ROM_ADDR returns to 0 and the first note replays; without the macro, it SHALL check that DONE holds INX = 0 indefinitely.
REQ-033 The bench SHALL flip SONG_SEL mid-note coincident with BEAT_EN, and SHALL check that within 3 cycles ROM_ADDR = 139, INX = 0, and the song-1 first note then loads.
REQ-034 The bench SHALL set ROM[255] = 8'h01 for a song starting at 8'd254, and SHALL check that ROM_ADDR wraps from 255 to 0 after playing that note.
REQ-035 The bench SHALL assert RST_N low mid-PLAY, and SHALL check that all outputs reach reset values asynchronously and that playback restarts from the base address after release.

Source files
------------

// File: rtl/note_seq_pkg.sv
`default_nettype none
// note_seq_pkg -- shared types and constants for the note sequencer.  Rev 1.0
package note_seq_pkg;
  localparam int NOTE_W = 4;
  localparam int DUR_W  = 4;
  localparam logic [NOTE_W-1:0] END_CODE  = 4'hF;
  localparam logic [NOTE_W-1:0] REST_CODE = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;
endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// sync_2ff -- 1-bit two-flop synchronizer with asynchronous active-low clear.  Rev 1.0
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// note_sequencer -- walks a music ROM and presents one note per duration; define
// NOTE_SEQ_LOOP_EN to loop a song at its end marker instead of stopping.  Rev 1.0
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter logic [7:0] SONG0_BASE = 8'd0,
  parameter logic [7:0] SONG1_BASE = 8'd139
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              beat_en,
  input  logic              song_sel,
  input  logic              pause,
  output logic [7:0]        rom_addr,
  input  logic [7:0]        rom_q,
  output logic [NOTE_W-1:0] inx,
  output logic              note_valid,
  output logic              song_id
);
  state_t            state, state_nx;
  logic [7:0]        addr_r, addr_nx;
  logic [NOTE_W-1:0] inx_r, inx_nx;
  logic              valid_r, valid_nx;
  logic [DUR_W:0]    remaining, remaining_nx;
  logic              song_prev;
  logic              song_chg;
  logic [7:0]        cur_base;
  logic [7:0]        new_base;
  logic [NOTE_W-1:0] note_code;
  logic [DUR_W-1:0]  note_dur;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (song_sel),
    .q     (song_id)
  );

  assign song_chg  = (song_id != song_prev);
  assign cur_base  = song_prev ? SONG1_BASE : SONG0_BASE;
  assign new_base  = song_id ? SONG1_BASE : SONG0_BASE;
  assign note_code = rom_q[NOTE_W-1:0];
  assign note_dur  = rom_q[NOTE_W +: DUR_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr_r    <= SONG0_BASE;
      inx_r     <= REST_CODE;
      valid_r   <= 1'b0;
      remaining <= '0;
      song_prev <= 1'b0;
    end else begin
      state     <= state_nx;
      addr_r    <= addr_nx;
      inx_r     <= inx_nx;
      valid_r   <= valid_nx;
      remaining <= remaining_nx;
      song_prev <= song_id;
    end
  end

  always_comb begin
    state_nx     = state;
    addr_nx      = addr_r;
    inx_nx       = inx_r;
    valid_nx     = valid_r;
    remaining_nx = remaining;
    // A song change overrides pause and beats; pause freezes everything else.
    if (song_chg) begin
      state_nx     = ST_FETCH;
      addr_nx      = new_base;
      inx_nx       = REST_CODE;
      valid_nx     = 1'b0;
      remaining_nx = '0;
    end else if (!pause) begin
      case (state)
        ST_IDLE:  state_nx = ST_FETCH;
        ST_FETCH: state_nx = ST_LOAD;
        ST_LOAD: begin
          if (note_code != END_CODE) begin
            inx_nx       = note_code;
            remaining_nx = {1'b0, note_dur} + {{DUR_W{1'b0}}, 1'b1};
            valid_nx     = 1'b1;
            addr_nx      = addr_r + 8'd1;
            state_nx     = ST_PLAY;
          end else if (addr_r == cur_base) begin
            // Empty song: stopping here avoids refetching the marker forever.
            state_nx = ST_DONE;
            inx_nx   = REST_CODE;
            valid_nx = 1'b0;
          end else begin
`ifdef NOTE_SEQ_LOOP_EN
            addr_nx  = cur_base;
            state_nx = ST_FETCH;
`else
            state_nx = ST_DONE;
            inx_nx   = REST_CODE;
            valid_nx = 1'b0;
`endif
          end
        end
        ST_PLAY: begin
          if (beat_en) begin
            if (remaining == {{DUR_W{1'b0}}, 1'b1})
              state_nx = ST_FETCH;
            else
              remaining_nx = remaining - {{DUR_W{1'b0}}, 1'b1};
          end
        end
        ST_DONE:  state_nx = ST_DONE;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  assign rom_addr   = addr_r;
  assign inx        = pause ? REST_CODE : inx_r;
  assign note_valid = valid_r & ~pause;
endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// tb_note_sequencer -- directed scoreboard bench for note_sequencer.  Rev 1.0
module tb_note_sequencer;
  logic       clk;
  logic       rst_n;
  logic       beat_en;
  logic       beat2;
  logic       song_sel;
  logic       pause;
  logic [7:0] rom_addr, rom_q;
  logic [3:0] inx;
  logic       note_valid;
  logic       song_id;
  logic [7:0] w_addr, w_q;
  logic [3:0] w_inx;
  logic       w_valid;
  logic       w_song;
  logic       tie0;

  logic [7:0] mem [256];

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  note_sequencer u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .beat_en    (beat_en),
    .song_sel   (song_sel),
    .pause      (pause),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .inx        (inx),
    .note_valid (note_valid),
    .song_id    (song_id)
  );

  note_sequencer #(.SONG0_BASE(8'd254), .SONG1_BASE(8'd139)) u_wrap (
    .clk        (clk),
    .rst_n      (rst_n),
    .beat_en    (beat2),
    .song_sel   (tie0),
    .pause      (tie0),
    .rom_addr   (w_addr),
    .rom_q      (w_q),
    .inx        (w_inx),
    .note_valid (w_valid),
    .song_id    (w_song)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_q <= mem[rom_addr];
    w_q   <= mem[w_addr];
  end

  task automatic want(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [7:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic beat();
    @(negedge clk) beat_en = 1'b1;
    @(negedge clk) beat_en = 1'b0;
  endtask

  task automatic check_note(input string tag, input logic [3:0] code, input logic vld);
    want({tag, "_inx"}, {4'b0, code});
    want({tag, "_valid"}, {7'b0, vld});
    chk({4'b0, inx});
    chk({7'b0, note_valid});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h0F;
    mem[0]   = 8'h25;
    mem[1]   = 8'h06;
    mem[2]   = 8'h17;
    mem[3]   = 8'h0F;
    mem[139] = 8'h09;
    mem[140] = 8'h0F;
    mem[254] = 8'h03;
    mem[255] = 8'h01;

    rst_n = 1'b0; beat_en = 1'b0; beat2 = 1'b0; song_sel = 1'b0; pause = 1'b0; tie0 = 1'b0;
    repeat (3) @(negedge clk);
    want("rst_addr", 8'd0); chk(rom_addr);
    check_note("rst", 4'h0, 1'b0);
    want("rst_song", 8'd0); chk({7'b0, song_id});

    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_note("first", 4'h5, 1'b1);
    want("first_addr", 8'd1); chk(rom_addr);

    // Asynchronous reset in the middle of a clock phase while a note plays.
    beat();
    #2 rst_n = 1'b0;
    #1;
    check_note("async_rst", 4'h0, 1'b0);
    want("async_rst_addr", 8'd0); chk(rom_addr);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_note("restart", 4'h5, 1'b1);
    want("restart_addr", 8'd1); chk(rom_addr);

    // Note 5 lasts three beats, note 6 follows two cycles after the third.
    beat(); check_note("beat1", 4'h5, 1'b1);
    beat(); check_note("beat2", 4'h5, 1'b1);
    beat(); check_note("fetch_hold", 4'h5, 1'b1);
    @(negedge clk); check_note("load_hold", 4'h5, 1'b1);
    @(negedge clk); check_note("second", 4'h6, 1'b1);
    want("second_addr", 8'd2); chk(rom_addr);
    beat();
    repeat (2) @(negedge clk);
    check_note("third", 4'h7, 1'b1);
    want("third_addr", 8'd3); chk(rom_addr);

    // Pause for ten beats during the two-beat note.
    pause = 1'b1;
    @(negedge clk); check_note("paused", 4'h0, 1'b0);
    repeat (10) beat();
    check_note("paused_long", 4'h0, 1'b0);
    pause = 1'b0;
    @(negedge clk); check_note("resume", 4'h7, 1'b1);
    beat();
    repeat (2) @(negedge clk);
    check_note("resume_rem1", 4'h7, 1'b1);
    beat();
    repeat (2) @(negedge clk);
`ifdef NOTE_SEQ_LOOP_EN
    want("loop_addr", 8'd0); chk(rom_addr);
    check_note("loop_hold", 4'h7, 1'b1);
    repeat (2) @(negedge clk);
    check_note("loop_replay", 4'h5, 1'b1);
    want("loop_replay_addr", 8'd1); chk(rom_addr);
`else
    check_note("done", 4'h0, 1'b0);
    repeat (4) beat();
    repeat (20) @(negedge clk);
    check_note("done_hold", 4'h0, 1'b0);
    want("done_addr", 8'd3); chk(rom_addr);
`endif

    // Restart song 0, then switch songs with a beat in the change cycle.
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_note("pre_switch", 4'h5, 1'b1);
    song_sel = 1'b1;
    @(negedge clk);
    @(negedge clk);
    want("song_id", 8'd1); chk({7'b0, song_id});
    check_note("switch_pending", 4'h5, 1'b1);
    beat_en = 1'b1;
    @(negedge clk) beat_en = 1'b0;
    want("switch_addr", 8'd139); chk(rom_addr);
    check_note("switch", 4'h0, 1'b0);
    repeat (2) @(negedge clk);
    check_note("song1_first", 4'h9, 1'b1);
    want("song1_addr", 8'd140); chk(rom_addr);

    // Song starting at 254 wraps the address through 255 to 0.
    want("wrap_pre_addr", 8'd255); chk(w_addr);
    want("wrap_pre_inx", 8'd3); chk({4'b0, w_inx});
    @(negedge clk) beat2 = 1'b1;
    @(negedge clk) beat2 = 1'b0;
    repeat (2) @(negedge clk);
    want("wrap_inx", 8'd1); chk({4'b0, w_inx});
    want("wrap_addr", 8'd0); chk(w_addr);
    @(negedge clk) beat2 = 1'b1;
    @(negedge clk) beat2 = 1'b0;
    repeat (2) @(negedge clk);
    want("wrap_next_inx", 8'd5); chk({4'b0, w_inx});
    want("wrap_next_addr", 8'd1); chk(w_addr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
